// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to instruction memory over a
// req/ack handshake, buffers returned words in a prefetch queue and presents
// the head to the decoder over valid/ready. Redirects flush the queue and
// abandon any in-flight fetch.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req/imem_addr              read request and word address
//   imem_ack/imem_rdata             accept strobe and returned word
//   redirect/redirect_pc            PC load from the PC-select logic
//   inst_valid/inst_ready           decoder handshake on queue head
//   inst_data/inst_pc/inst_pc_plus4 head instruction, its PC, and PC + 4
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] RST_PC_W = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pc_plus4_q, pc_plus4_d;

    logic [31:0]        pc_mem_q   [DEPTH];
    logic [31:0]        data_mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   cnt_after;
    logic               unused_rpc_lsb;

    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // Next state, queue bookkeeping and registered head outputs
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        data_d     = data_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        push       = 1'b0;
        pop        = (count_q != '0) && inst_ready && !redirect;
        cnt_after  = count_q + CNT_W'(1) - CNT_W'(pop);

        case (state_q)
            IDLE: begin
                if (!redirect && (count_q < CNT_W'(DEPTH))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        state_d = IDLE;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = (cnt_after < CNT_W'(DEPTH)) ? REQ : IDLE;
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
        end

        // Abandoned request keeps its address on the bus until acked
        addr_d  = (state_d == DROP) ? addr_q : fetch_pc_d;
        valid_d = (count_d != '0);

        // Head outputs hold their last value while the queue is empty
        if (count_d != '0) begin
            if (push && (count_q == CNT_W'(pop))) begin
                pc_d   = fetch_pc_q;
                data_d = imem_rdata;
            end else begin
                pc_d   = pc_mem_q[rd_ptr_d];
                data_d = data_mem_q[rd_ptr_d];
            end
            pc_plus4_d = pc_d + 32'd4;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RST_PC_W;
            addr_q     <= RST_PC_W;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            pc_q       <= '0;
            pc_plus4_q <= 32'd4;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    // Queue storage; contents are only read once written
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            data_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req      = (state_q == REQ) || (state_q == DROP);
    assign imem_addr     = addr_q;
    assign inst_valid    = valid_q;
    assign inst_data     = data_q;
    assign inst_pc       = pc_q;
    assign inst_pc_plus4 = pc_plus4_q;

endmodule
